serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 99 +++++++++
 tb/tb_serial_adder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Digit-serial adder: sum = a + b + cin, DIGIT bits per clock, LSB digit first; done pulses
// WIDTH/DIGIT cycles after the start edge. start is ignored (no backpressure queue) while busy.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
            $error("serial_adder: DIGIT must be >= 1 and divide WIDTH exactly");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_psum;
    logic             r_carry;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [CW-1:0]    r_cnt;

    logic [DIGIT:0]         w_slice;
    logic [WIDTH+DIGIT-1:0] w_psum_ext;
    logic [WIDTH-1:0]       w_psum_next;

    assign w_slice     = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};
    // New digit enters at the top; after N steps the first digit has reached bit 0.
    assign w_psum_ext  = {w_slice[DIGIT-1:0], r_psum};
    assign w_psum_next = w_psum_ext[WIDTH+DIGIT-1:DIGIT];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_psum   <= '0;
            r_carry  <= 1'b0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_cnt    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= b[WIDTH-1];
                        r_psum  <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_carry <= w_slice[DIGIT];
                    r_psum  <= w_psum_next;
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        sum      <= w_psum_next;
                        cout     <= w_slice[DIGIT];
                        overflow <= (r_a_msb == r_b_msb) && (w_psum_next[WIDTH-1] != r_a_msb);
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: three configurations (1/1, 8/2, 16/4) driven with
// directed and random operands, expected results from plain integer addition.
module tb_serial_adder;
    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int cmp = 0;
    int bad = 0;
    exp_t q1[$], q8[$], q16[$];

    logic rst, rst8, rst_q, rst8_q;
    always @(posedge clk) begin
        rst_q  <= rst;
        rst8_q <= rst8;
    end

    logic        start1, a1, b1, cin1, busy1, done1, sum1, cout1, ovf1;
    logic        start8, cin8, busy8, done8, cout8, ovf8;
    logic [7:0]  a8, b8, sum8;
    logic        start16, cin16, busy16, done16, cout16, ovf16;
    logic [15:0] a16, b16, sum16;

    serial_adder #(.WIDTH(1), .DIGIT(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1));
    serial_adder #(.WIDTH(8), .DIGIT(2)) u8 (
        .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8));
    serial_adder #(.WIDTH(16), .DIGIT(4)) u16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .overflow(ovf16));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: w-bit modular addition; t is the cycle in which done must be seen.
    function automatic exp_t model(int w, logic [15:0] a, logic [15:0] b, logic c, int t);
        exp_t        e;
        logic [16:0] full;
        full   = {1'b0, a} + {1'b0, b} + {16'b0, c};
        e.sum  = full[15:0] & 16'((17'd1 << w) - 17'd1);
        e.cout = full[w];
        e.ovf  = (a[w-1] == b[w-1]) && (e.sum[w-1] != a[w-1]);
        e.cyc  = t;
        return e;
    endfunction

    // Each issue drives start in one cycle, then junk starts while the DUT is busy.
    task automatic issue1(input logic a, input logic b, input logic c);
        @(negedge clk);
        a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
        q1.push_back(model(1, 16'(a), 16'(b), c, cyc + 2));
        @(negedge clk);
        a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom); start1 = 1'($urandom);
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c);
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        q8.push_back(model(8, 16'(a), 16'(b), c, cyc + 5));
        repeat (4) begin
            @(negedge clk);
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); start8 = 1'($urandom);
        end
    endtask

    task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic c);
        @(negedge clk);
        a16 = a; b16 = b; cin16 = c; start16 = 1'b1;
        q16.push_back(model(16, a, b, c, cyc + 5));
        repeat (4) begin
            @(negedge clk);
            a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); start16 = 1'($urandom);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done1 === 1'b1) begin
                if (q1.size() == 0) check("u1 spurious done", 32'd1, 32'd0);
                else begin
                    e = q1.pop_front();
                    check("u1 sum", 32'(sum1), 32'(e.sum[0]));
                    check("u1 cout", 32'(cout1), 32'(e.cout));
                    check("u1 latency", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    initial begin
        exp_t       e;
        logic [9:0] h8;
        h8 = '0;
        forever begin
            @(negedge clk);
            if (rst8_q === 1'b1) h8 = '0;
            if (done8 === 1'b1) begin
                if (q8.size() == 0) check("u8 spurious done", 32'd1, 32'd0);
                else begin
                    e = q8.pop_front();
                    check("u8 sum", 32'(sum8), 32'(e.sum));
                    check("u8 cout", 32'(cout8), 32'(e.cout));
                    check("u8 overflow", 32'(ovf8), 32'(e.ovf));
                    check("u8 latency", 32'(cyc), 32'(e.cyc));
                    h8 = {e.ovf, e.cout, e.sum[7:0]};
                end
            end else check("u8 hold", 32'({ovf8, cout8, sum8}), 32'(h8));
        end
    end

    initial begin
        exp_t        e;
        logic [17:0] h16;
        h16 = '0;
        forever begin
            @(negedge clk);
            if (rst_q === 1'b1) h16 = '0;
            if (done16 === 1'b1) begin
                if (q16.size() == 0) check("u16 spurious done", 32'd1, 32'd0);
                else begin
                    e = q16.pop_front();
                    check("u16 sum", 32'(sum16), 32'(e.sum));
                    check("u16 cout", 32'(cout16), 32'(e.cout));
                    check("u16 overflow", 32'(ovf16), 32'(e.ovf));
                    check("u16 latency", 32'(cyc), 32'(e.cyc));
                    h16 = {e.ovf, e.cout, e.sum};
                end
            end else check("u16 hold", 32'({ovf16, cout16, sum16}), 32'(h16));
        end
    end

    initial begin
        rst = 1'b1; rst8 = 1'b1;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy8", 32'(busy8), 32'd0);
        check("reset done8", 32'(done8), 32'd0);
        check("reset sum8", 32'(sum8), 32'd0);
        check("reset cout8", 32'(cout8), 32'd0);
        check("reset ovf8", 32'(ovf8), 32'd0);
        check("reset busy16", 32'(busy16), 32'd0);
        check("reset sum16", 32'(sum16), 32'd0);
        check("reset busy1", 32'(busy1), 32'd0);
        check("reset sum1", 32'(sum1), 32'd0);
        rst = 1'b0; rst8 = 1'b0;

        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 8; i++) begin
                logic [2:0] v;
                v = 3'(i);
                issue1(v[2], v[1], v[0]);
            end
        end
        @(negedge clk); start1 = 1'b0;

        issue16(16'hFFFF, 16'h0001, 1'b0);
        issue16(16'h1234, 16'h4321, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 2) == 0) begin @(negedge clk); start16 = 1'b0; end
            issue16(16'($urandom), 16'($urandom), 1'($urandom));
        end
        @(negedge clk); start16 = 1'b0;

        issue8(8'hFF, 8'h01, 1'b0);
        issue8(8'h7F, 8'h01, 1'b0);
        issue8(8'h80, 8'h80, 1'b0);
        issue8(8'h3C, 8'hA5, 1'b1);
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) == 0) begin @(negedge clk); start8 = 1'b0; end
            issue8(8'($urandom), 8'($urandom), 1'($urandom));
        end

        // Abandon an operation two cycles into RUN.
        @(negedge clk); a8 = 8'h55; b8 = 8'h66; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        @(negedge clk); rst8 = 1'b1;
        @(negedge clk); rst8 = 1'b0;
        check("midrun rst busy8", 32'(busy8), 32'd0);
        check("midrun rst sum8", 32'(sum8), 32'd0);
        check("midrun rst done8", 32'(done8), 32'd0);
        // Reset must win over a simultaneous start.
        @(negedge clk); rst8 = 1'b1; start8 = 1'b1;
        @(negedge clk); rst8 = 1'b0; start8 = 1'b0;
        check("rst over start busy8", 32'(busy8), 32'd0);
        issue8(8'h10, 8'h20, 1'b0);
        @(negedge clk); start8 = 1'b0;

        for (int i = 0; i < 40 && (q1.size() + q8.size() + q16.size()) > 0; i++) @(negedge clk);
        check("u1 results drained", 32'(q1.size()), 32'd0);
        check("u8 results drained", 32'(q8.size()), 32'd0);
        check("u16 results drained", 32'(q16.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
